rggen_apb_csr_array: RTL and testbench
======================================

RGGEN_APB_CSR_ARRAY -- requirements
Module: rggen_apb_csr_array

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 7, meaning the byte-address width of paddr.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning the register and bus width; only 32 is legal.
REQ-003 SHALL have parameter NUM_REGS, default 3, meaning the number of RW data registers; legal range 1..30.
REQ-004 SHALL have parameter INITIAL_VALUE, default 32'h0000_0000, meaning the reset value of every data register.
REQ-005 SHALL have parameter WAIT_CYCLES, default 0, meaning the number of access-phase wait states before pready; legal range 0..3.
REQ-006 clk  input  1  sole clock; all state updates on the rising edge.
REQ-007 rst_n  input  1  synchronous reset, active-low, sampled on the clk rising edge.
REQ-008 psel, penable, pwrite  input  1 each  APB control.
REQ-009 paddr  input  ADDRESS_WIDTH  byte address.
REQ-010 pwdata  input  32  write data.
REQ-011 pstrb  input  4  byte write strobes.
REQ-012 pready, pslverr  output  1 each  APB completion and error.
REQ-013 prdata  output  32  read data.
REQ-014 o_value  output  NUM_REGS*32  data register k on bits [32k+31:32k].
REQ-015 i_event  input  NUM_REGS  per-register event pulses.
REQ-016 o_irq  output  1  registered interrupt request.

Function
REQ-017 Address map SHALL be: data register k at 4k; STATUS (W1C, bit k) at 4*NUM_REGS; ENABLE (RW, bit k) at 4*NUM_REGS+4; all bits of STATUS and ENABLE above NUM_REGS-1 read 0 and ignore writes.
REQ-018 The FSM SHALL have states IDLE, WAIT and DONE.
REQ-019 IDLE SHALL go to WAIT on psel=1 with penable=1 when WAIT_CYCLES>0, or to DONE when WAIT_CYCLES=0.
REQ-020 WAIT SHALL count WAIT_CYCLES cycles and then go to DONE.
REQ-021 DONE SHALL drive pready=1 for exactly one cycle and then return to IDLE.
REQ-022 Completion latency SHALL be WAIT_CYCLES+1 cycles after the first access-phase cycle.
REQ-023 If psel deasserts in WAIT, the FSM SHALL return to IDLE with no write, no pready and no register change.
REQ-024 Writes SHALL commit only on the DONE cycle, byte lane by byte lane per pstrb; pstrb=0 SHALL leave the register unchanged with no error.
REQ-025 Read data SHALL be registered and valid on prdata only when pready=1; prdata SHALL be 0 at all other times.
REQ-026 An access to an unmapped address (>= 4*NUM_REGS+8) or with paddr[1:0]!=0 SHALL complete with pready=1, pslverr=1 and prdata=0, and SHALL change no state.
REQ-027 Each cycle, a STATUS bit k SHALL set when i_event[k]=1.
REQ-028 A STATUS bit k SHALL clear on a committed STATUS write with pwdata[k]=1 and its byte strobe set.
REQ-029 When set and clear of a STATUS bit occur in the same cycle, set SHALL win.
REQ-030 o_irq SHALL be registered: o_irq(next) = OR over k of (STATUS[k] & ENABLE[k]), i.e. one cycle after the contributing state.
REQ-031 pslverr SHALL be 0 whenever pready=0.

Reset
REQ-032 While rst_n=0 at a clk edge: FSM to IDLE; pready, pslverr and o_irq 0; prdata 0; data registers to INITIAL_VALUE; STATUS and ENABLE 0.
REQ-033 Reset asserted mid-transfer SHALL abort the transfer with no write; pready SHALL be 0 from the next cycle.
REQ-034 Events SHALL be ignored while rst_n=0.

Verification
REQ-035 WAIT_CYCLES=2, write 32'hDEAD_BEEF to 0x04 with pstrb=4'hF -> pready=1 on the 3rd access cycle; o_value[63:32]=32'hDEAD_BEEF the following cycle; read back matches.
REQ-036 pstrb=4'b0010 write of 32'h1234_5678 to 0x00 after reset -> o_value[31:0]=32'h0000_5600.
REQ-037 NUM_REGS=3, read 0x14 -> pready=1, pslverr=1, prdata=0; read 0x02 -> pslverr=1; no register change in either case.
REQ-038 ENABLE=3'b010, pulse i_event[1] -> STATUS reads 3'b010 and o_irq=1 one cycle later; write 32'h2 to STATUS -> o_irq=0 one cycle after commit.
REQ-039 i_event[0]=1 in the same cycle as a W1C of bit 0 -> STATUS[0] remains 1.
REQ-040 Assert rst_n=0 during WAIT of a write -> target register keeps INITIAL_VALUE; pready=0 the next cycle.

Source files
------------

// File: rtl/rggen_apb_csr_array.sv
// APB slave with an array of RW data registers plus a W1C event STATUS
// register and an interrupt ENABLE register driving a registered o_irq.
module rggen_apb_csr_array #(
    parameter int                ADDRESS_WIDTH = 7,
    parameter int                DATA_WIDTH    = 32,
    parameter int                NUM_REGS      = 3,
    parameter logic [31:0]       INITIAL_VALUE = 32'h0000_0000,
    parameter int                WAIT_CYCLES   = 0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           psel,
    input  logic                           penable,
    input  logic                           pwrite,
    input  logic [ADDRESS_WIDTH-1:0]       paddr,
    input  logic [DATA_WIDTH-1:0]          pwdata,
    input  logic [DATA_WIDTH/8-1:0]        pstrb,
    output logic                           pready,
    output logic                           pslverr,
    output logic [DATA_WIDTH-1:0]          prdata,
    output logic [NUM_REGS*DATA_WIDTH-1:0] o_value,
    input  logic [NUM_REGS-1:0]            i_event,
    output logic                           o_irq
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t                  state;
    logic [1:0]              wait_cnt;
    logic [DATA_WIDTH-1:0]   value [NUM_REGS];
    logic [NUM_REGS-1:0]     status;
    logic [NUM_REGS-1:0]     enable;

    logic [31:0]             addr_ext;
    logic [29:0]             word_idx;
    logic                    addr_err;
    logic                    access;
    logic                    wait_last;
    logic                    finish;
    logic                    commit;
    logic [DATA_WIDTH-1:0]   wmask;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [NUM_REGS-1:0]     status_clr;

    function automatic logic [DATA_WIDTH-1:0] strb_mask(input logic [DATA_WIDTH/8-1:0] strb);
        strb_mask = '0;
        for (int b = 0; b < DATA_WIDTH/8; b++) begin
            strb_mask[8*b +: 8] = {8{strb[b]}};
        end
    endfunction

    assign addr_ext  = 32'(paddr);
    assign word_idx  = addr_ext[31:2];
    // Words 0..NUM_REGS-1 are data, NUM_REGS is STATUS, NUM_REGS+1 is ENABLE.
    assign addr_err  = (addr_ext[1:0] != 2'b00) || (word_idx > 30'(NUM_REGS + 1));
    assign access    = psel && penable;
    assign wait_last = (WAIT_CYCLES == 0) || (wait_cnt == 2'(WAIT_CYCLES - 1));
    assign commit    = (state == DONE) && psel && pwrite && !addr_err;
    assign wmask     = strb_mask(pstrb);

    always_comb begin
        finish = 1'b0;
        if (state == IDLE && access && WAIT_CYCLES == 0) begin
            finish = 1'b1;
        end else if (state == WAIT && psel && wait_last) begin
            finish = 1'b1;
        end
    end

    always_comb begin
        rdata = '0;
        if (!addr_err) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (word_idx == 30'(k)) begin
                    rdata = value[k];
                end
            end
            if (word_idx == 30'(NUM_REGS)) begin
                rdata[NUM_REGS-1:0] = status;
            end
            if (word_idx == 30'(NUM_REGS + 1)) begin
                rdata[NUM_REGS-1:0] = enable;
            end
        end
    end

    always_comb begin
        status_clr = '0;
        if (commit && word_idx == 30'(NUM_REGS)) begin
            status_clr = pwdata[NUM_REGS-1:0] & wmask[NUM_REGS-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            wait_cnt <= '0;
            pready   <= 1'b0;
            pslverr  <= 1'b0;
            prdata   <= '0;
            o_irq    <= 1'b0;
            status   <= '0;
            enable   <= '0;
            for (int k = 0; k < NUM_REGS; k++) begin
                value[k] <= INITIAL_VALUE;
            end
        end else begin
            pready  <= finish;
            pslverr <= finish && addr_err;
            prdata  <= (finish && !pwrite) ? rdata : '0;

            case (state)
                IDLE: begin
                    wait_cnt <= '0;
                    if (access) begin
                        state <= (WAIT_CYCLES == 0) ? DONE : WAIT;
                    end
                end
                WAIT: begin
                    if (!psel) begin
                        state <= IDLE;
                    end else if (wait_last) begin
                        state <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase

            if (commit) begin
                for (int k = 0; k < NUM_REGS; k++) begin
                    if (word_idx == 30'(k)) begin
                        value[k] <= (value[k] & ~wmask) | (pwdata & wmask);
                    end
                end
                if (word_idx == 30'(NUM_REGS + 1)) begin
                    enable <= (enable & ~wmask[NUM_REGS-1:0]) |
                              (pwdata[NUM_REGS-1:0] & wmask[NUM_REGS-1:0]);
                end
            end

            // A new event in the same cycle as a W1C keeps the bit set.
            status <= (status & ~status_clr) | i_event;
            o_irq  <= |(status & enable);
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_value
        assign o_value[DATA_WIDTH*k +: DATA_WIDTH] = value[k];
    end

endmodule

// File: tb/tb_rggen_apb_csr_array.sv
// Directed bench for rggen_apb_csr_array with NUM_REGS=3 and two wait states.
module tb_rggen_apb_csr_array;

    localparam int AW = 7;
    localparam int NR = 3;
    localparam int WC = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          psel = 1'b0;
    logic          penable = 1'b0;
    logic          pwrite = 1'b0;
    logic [AW-1:0] paddr = '0;
    logic [31:0]   pwdata = '0;
    logic [3:0]    pstrb = '0;
    logic          pready;
    logic          pslverr;
    logic [31:0]   prdata;
    logic [NR*32-1:0] o_value;
    logic [NR-1:0] i_event = '0;
    logic          o_irq;

    int n_checks = 0;
    int n_pass   = 0;

    rggen_apb_csr_array #(
        .ADDRESS_WIDTH(AW),
        .DATA_WIDTH   (32),
        .NUM_REGS     (NR),
        .INITIAL_VALUE(32'h0000_0000),
        .WAIT_CYCLES  (WC)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .psel   (psel),
        .penable(penable),
        .pwrite (pwrite),
        .paddr  (paddr),
        .pwdata (pwdata),
        .pstrb  (pstrb),
        .pready (pready),
        .pslverr(pslverr),
        .prdata (prdata),
        .o_value(o_value),
        .i_event(i_event),
        .o_irq  (o_irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full APB transfer; ev is driven on i_event during the completion cycle.
    task automatic apb_xfer(input logic wr, input logic [AW-1:0] addr, input logic [31:0] wdata,
                            input logic [3:0] strb, input logic [NR-1:0] ev,
                            output logic [31:0] rdata, output logic err, output int lat);
        logic got;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata; pstrb = strb;
        tick();
        penable = 1'b1;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 20) begin
            tick();
            lat++;
            if (pready) got = 1'b1;
        end
        if (!got) check("xfer_timeout", {31'd0, pready}, 32'd1);
        rdata = prdata;
        err = pslverr;
        i_event = ev;
        tick();
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; pstrb = '0; i_event = '0;
        check("pready_one_cycle", {31'd0, pready}, 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        logic        seen;
        int          lat;

        tick(); tick(); tick();
        check("rst_pready",  {31'd0, pready},  32'd0);
        check("rst_pslverr", {31'd0, pslverr}, 32'd0);
        check("rst_prdata",  prdata,           32'd0);
        check("rst_irq",     {31'd0, o_irq},   32'd0);
        check("rst_reg1",    o_value[63:32],   32'd0);
        rst_n = 1'b1;
        tick();

        // Full-word write with two wait states, then read back.
        apb_xfer(1'b1, 7'h04, 32'hDEAD_BEEF, 4'hF, '0, rd, er, lat);
        check("wr_latency", lat, WC + 1);
        check("wr_err",     {31'd0, er}, 32'd0);
        check("wr_value1",  o_value[63:32], 32'hDEAD_BEEF);
        check("idle_prdata", prdata, 32'd0);
        apb_xfer(1'b0, 7'h04, 32'd0, 4'h0, '0, rd, er, lat);
        check("rd_latency", lat, WC + 1);
        check("rd_value1",  rd, 32'hDEAD_BEEF);

        // Byte-lane write after reset; zero strobe is a no-op.
        do_reset();
        check("reset_reg1", o_value[63:32], 32'd0);
        apb_xfer(1'b1, 7'h00, 32'h1234_5678, 4'b0010, '0, rd, er, lat);
        check("strb_reg0", o_value[31:0], 32'h0000_5600);
        apb_xfer(1'b1, 7'h08, 32'hFFFF_FFFF, 4'b0000, '0, rd, er, lat);
        check("strb0_err",  {31'd0, er}, 32'd0);
        check("strb0_reg2", o_value[95:64], 32'd0);

        // Unmapped and misaligned accesses.
        apb_xfer(1'b0, 7'h14, 32'd0, 4'h0, '0, rd, er, lat);
        check("unmap_rd_err",  {31'd0, er}, 32'd1);
        check("unmap_rd_data", rd, 32'd0);
        check("unmap_pslverr_after", {31'd0, pslverr}, 32'd0);
        apb_xfer(1'b0, 7'h02, 32'd0, 4'h0, '0, rd, er, lat);
        check("misalign_rd_err",  {31'd0, er}, 32'd1);
        check("misalign_rd_data", rd, 32'd0);
        apb_xfer(1'b1, 7'h02, 32'hFFFF_FFFF, 4'hF, '0, rd, er, lat);
        check("misalign_wr_err", {31'd0, er}, 32'd1);
        check("misalign_wr_reg0", o_value[31:0], 32'h0000_5600);
        apb_xfer(1'b1, 7'h14, 32'hFFFF_FFFF, 4'hF, '0, rd, er, lat);
        check("unmap_wr_err", {31'd0, er}, 32'd1);
        check("unmap_wr_regs", o_value[95:64] | o_value[63:32], 32'd0);

        // ENABLE upper bits read as zero.
        apb_xfer(1'b1, 7'h10, 32'hFFFF_FFFF, 4'hF, '0, rd, er, lat);
        apb_xfer(1'b0, 7'h10, 32'd0, 4'h0, '0, rd, er, lat);
        check("enable_mask", rd, 32'h0000_0007);
        apb_xfer(1'b1, 7'h10, 32'h0000_0002, 4'hF, '0, rd, er, lat);
        apb_xfer(1'b0, 7'h10, 32'd0, 4'h0, '0, rd, er, lat);
        check("enable_rd", rd, 32'h0000_0002);

        // Event on bit 1 raises o_irq one cycle after STATUS sets.
        i_event = 3'b010;
        tick();
        i_event = '0;
        check("irq_lag", {31'd0, o_irq}, 32'd0);
        tick();
        check("irq_set", {31'd0, o_irq}, 32'd1);
        apb_xfer(1'b0, 7'h0C, 32'd0, 4'h0, '0, rd, er, lat);
        check("status_rd", rd, 32'h0000_0002);
        apb_xfer(1'b1, 7'h0C, 32'h0000_0002, 4'hF, '0, rd, er, lat);
        check("irq_hold_after_commit", {31'd0, o_irq}, 32'd1);
        tick();
        check("irq_clear", {31'd0, o_irq}, 32'd0);
        apb_xfer(1'b0, 7'h0C, 32'd0, 4'h0, '0, rd, er, lat);
        check("status_clr_rd", rd, 32'd0);

        // Set wins over a simultaneous W1C; a plain W1C clears.
        i_event = 3'b001;
        tick();
        i_event = '0;
        apb_xfer(1'b1, 7'h0C, 32'h0000_0001, 4'hF, 3'b001, rd, er, lat);
        apb_xfer(1'b0, 7'h0C, 32'd0, 4'h0, '0, rd, er, lat);
        check("set_wins", rd, 32'h0000_0001);
        apb_xfer(1'b1, 7'h0C, 32'h0000_0001, 4'hE, '0, rd, er, lat);
        apb_xfer(1'b0, 7'h0C, 32'd0, 4'h0, '0, rd, er, lat);
        check("w1c_strb_off", rd, 32'h0000_0001);
        apb_xfer(1'b1, 7'h0C, 32'h0000_0001, 4'h1, '0, rd, er, lat);
        apb_xfer(1'b0, 7'h0C, 32'd0, 4'h0, '0, rd, er, lat);
        check("w1c_clear", rd, 32'd0);

        // psel dropped during WAIT: no completion, no write.
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 7'h08; pwdata = 32'hAAAA_5555; pstrb = 4'hF;
        tick();
        penable = 1'b1;
        tick();
        psel = 1'b0; penable = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            seen = seen | pready;
        end
        check("abort_no_pready", {31'd0, seen}, 32'd0);
        check("abort_no_write", o_value[95:64], 32'd0);

        // Reset during WAIT of a write; events ignored under reset.
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 7'h08; pwdata = 32'hCAFE_F00D; pstrb = 4'hF;
        tick();
        penable = 1'b1;
        tick();
        rst_n = 1'b0;
        i_event = 3'b111;
        tick();
        check("rst_abort_pready", {31'd0, pready}, 32'd0);
        psel = 1'b0; penable = 1'b0;
        tick();
        check("rst_abort_pready2", {31'd0, pready}, 32'd0);
        rst_n = 1'b1;
        i_event = '0;
        tick();
        check("rst_abort_reg2", o_value[95:64], 32'd0);
        check("rst_irq_low", {31'd0, o_irq}, 32'd0);
        apb_xfer(1'b0, 7'h0C, 32'd0, 4'h0, '0, rd, er, lat);
        check("rst_event_ignored", rd, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
